dma_channel_arbiter: RTL and testbench
======================================

// Module: dma_channel_arbiter
// PURPOSE
// Shares the single DMA controller port among N_DEV DMA-capable peripherals (simple_dma_device style).
// Round-robin arbitration with whole-transfer granularity: a granted device owns the controller from rqst to end flag.
// Latches the winner's start address / word count / direction, muxes its data and ack, routes controller responses back.
// Adds a no-progress watchdog so a stalled device cannot lock the controller.
// PARAMETERS
// N_DEV     4    number of requesting devices (2..4)
// TIMEOUT   1024 cycles without dma_ack while in XFER before forced release; 0 disables watchdog
// PORTS
// clk               in   1        main system clock
// reset_n           in   1        asynchronous active-low reset
// dev_rqst          in   N_DEV    per-device dma_rqst
// dev_rd_wr         in   N_DEV    per-device direction (1 read, 0 write)
// dev_start_addr    in   16*N_DEV per-device start address, device i at [16i+15:16i]
// dev_num_words     in   16*N_DEV per-device word count
// dev_ack_in        in   N_DEV    per-device dev_ack (device ready)
// dev_wdata         in   16*N_DEV per-device write data (dev_out)
// dev_dma_ack       out  N_DEV    dma_ack routed to granted device only
// dev_end_flag      out  N_DEV    dma_end_flag routed to granted device only
// dev_rdata         out  16       controller read data, broadcast
// dma_rqst          out  1        request to DMA controller
// dma_rd_wr         out  1        latched direction of granted device
// dma_start_address out  16       latched start address
// dma_num_words     out  16       latched word count
// dma_dev_ack       out  1        granted device's dev_ack_in
// dma_dev_out       out  16       granted device's dev_wdata
// dma_ack           in   1        controller word acknowledge
// dma_end_flag      in   1        controller end-of-transfer
// dma_dev_in        in   16       controller read data
// grant             out  N_DEV    one-hot current owner (0 when none)
// busy              out  1        state != IDLE
// timeout_err       out  1        one-cycle pulse on watchdog release
// BEHAVIOUR
// - Reset: state IDLE, grant=0, dma_rqst=0, latched addr/words/rd_wr=0, rr pointer=0, watchdog=0, timeout_err=0.
// - FSM IDLE -> XFER -> RELEASE -> IDLE.
// - IDLE: if |dev_rqst, pick first requester at or after rr pointer (wrap N_DEV-1 -> 0); next edge: grant<=onehot,
//   latch its rd_wr/start_addr/num_words, state XFER. dma_rqst registered, high first cycle of XFER (1-cycle latency).
// - XFER: dma_rqst=1. dev_dma_ack/dev_end_flag = dma_ack/dma_end_flag gated by grant (combinational);
//   dma_dev_ack, dma_dev_out combinationally muxed from granted device; dev_rdata = dma_dev_in always.
//   Changes of a granted device's addr/words/rd_wr mid-XFER are ignored (latched values hold).
// - XFER exits to RELEASE on: dma_end_flag=1; granted dev_rqst=0 (CPU abort); watchdog hit. Priority: end > abort > timeout.
// - Watchdog: cleared on entry to XFER and on every dma_ack; increments otherwise; at TIMEOUT-1 -> RELEASE, timeout_err pulse.
// - RELEASE: dma_rqst=0, grant held (end/ack still routed). Leave to IDLE when granted dev_rqst=0 and dma_end_flag=0;
//   on exit grant<=0, rr pointer <= owner+1 mod N_DEV. No new grant before IDLE -> at least one idle cycle between owners.
// - Non-granted devices see dev_dma_ack=0, dev_end_flag=0 always; their rqst just waits.
// - Simultaneous requests in IDLE: rr order decides; same-cycle new request from owner in RELEASE exit is not granted until IDLE.
// - dma_ack/dma_end_flag in IDLE: ignored, not routed.
// - reset_n low mid-transfer: immediate return to reset values; dma_rqst drops asynchronously.
// TESTING
// - Single: dev1 rqst, addr 0x0200, words 4, rd -> dma_rqst next cycle, addr=0x0200, words=4, 4 acks to dev1 only, end -> IDLE, rr=2.
// - Contention: dev0,dev2 rqst same cycle, rr=0 -> dev0 first; after release dev2 granted; never overlapping grant, >=1 idle cycle.
// - Fairness: all 4 requesting continuously -> grant order 0,1,2,3,0 over 5 transfers.
// - Latch: dev3 changes start_addr 0x0300->0x0400 during XFER -> dma_start_address stays 0x0300.
// - Timeout TIMEOUT=16: granted, no dma_ack 16 cycles -> timeout_err pulse, dma_rqst=0, IDLE after dev rqst drops.
// - Abort/reset: owner drops rqst mid-XFER -> RELEASE next edge; reset_n low in XFER -> grant=0, dma_rqst=0 immediately.

Source files
------------

// File: rtl/dma_channel_arbiter.sv
// Round-robin arbiter sharing one DMA controller port among N_DEV devices.
// A grant lasts a whole transfer; a no-progress watchdog forces release of a stalled owner.
module dma_channel_arbiter #(
  parameter int N_DEV   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_DEV-1:0]      dev_rqst,
  input  logic [N_DEV-1:0]      dev_rd_wr,
  input  logic [16*N_DEV-1:0]   dev_start_addr,
  input  logic [16*N_DEV-1:0]   dev_num_words,
  input  logic [N_DEV-1:0]      dev_ack_in,
  input  logic [16*N_DEV-1:0]   dev_wdata,
  output logic [N_DEV-1:0]      dev_dma_ack,
  output logic [N_DEV-1:0]      dev_end_flag,
  output logic [15:0]           dev_rdata,
  output logic                  dma_rqst,
  output logic                  dma_rd_wr,
  output logic [15:0]           dma_start_address,
  output logic [15:0]           dma_num_words,
  output logic                  dma_dev_ack,
  output logic [15:0]           dma_dev_out,
  input  logic                  dma_ack,
  input  logic                  dma_end_flag,
  input  logic [15:0]           dma_dev_in,
  output logic [N_DEV-1:0]      grant,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IW = $clog2(N_DEV);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t           state_q;
  logic [N_DEV-1:0] grant_q;
  logic [IW-1:0]    owner_q, rr_q, rr_d;
  logic [15:0]      addr_q, words_q;
  logic             rd_wr_q, rqst_q, tmo_q;
  logic [WW-1:0]    wdog_q;

  logic [IW-1:0]    win_idx, cand;
  logic             win_vld, wdog_hit;
  logic [15:0]      dev_out_mux;

  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = N_DEV - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_q) + k) % N_DEV);
      if (dev_rqst[cand]) begin
        win_idx = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    dev_out_mux = '0;
    for (int i = 0; i < N_DEV; i++)
      if (grant_q[i]) dev_out_mux = dev_out_mux | dev_wdata[16*i +: 16];
  end

  assign rr_d     = (owner_q == IW'(N_DEV - 1)) ? '0 : owner_q + 1'b1;
  assign wdog_hit = (TIMEOUT != 0) && (wdog_q == WD_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= '0;
      addr_q  <= '0;
      words_q <= '0;
      rd_wr_q <= 1'b0;
      rqst_q  <= 1'b0;
      wdog_q  <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_vld) begin
            grant_q <= {{(N_DEV-1){1'b0}}, 1'b1} << win_idx;
            owner_q <= win_idx;
            addr_q  <= dev_start_addr[16*win_idx +: 16];
            words_q <= dev_num_words[16*win_idx +: 16];
            rd_wr_q <= dev_rd_wr[win_idx];
            rqst_q  <= 1'b1;
            wdog_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (dma_end_flag || !dev_rqst[owner_q]) begin
            rqst_q  <= 1'b0;
            state_q <= RELEASE;
          end else if (dma_ack) begin
            wdog_q <= '0;
          end else if (wdog_hit) begin
            rqst_q  <= 1'b0;
            tmo_q   <= 1'b1;
            state_q <= RELEASE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        RELEASE: begin
          // Owner must withdraw and the controller must be quiet before the bus is reoffered.
          if (!dev_rqst[owner_q] && !dma_end_flag) begin
            grant_q <= '0;
            rr_q    <= rr_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dev_dma_ack       = grant_q & {N_DEV{dma_ack}};
  assign dev_end_flag      = grant_q & {N_DEV{dma_end_flag}};
  assign dev_rdata         = dma_dev_in;
  assign dma_rqst          = rqst_q;
  assign dma_rd_wr         = rd_wr_q;
  assign dma_start_address = addr_q;
  assign dma_num_words     = words_q;
  assign dma_dev_ack       = |(grant_q & dev_ack_in);
  assign dma_dev_out       = dev_out_mux;
  assign grant             = grant_q;
  assign busy              = (state_q != IDLE);
  assign timeout_err       = tmo_q;

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter (N_DEV=4, TIMEOUT=16).
module tb_dma_channel_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  dev_rqst, dev_rd_wr, dev_ack_in;
  logic [63:0] dev_start_addr, dev_num_words, dev_wdata;
  logic [3:0]  dev_dma_ack, dev_end_flag, grant;
  logic [15:0] dev_rdata, dma_start_address, dma_num_words, dma_dev_out, dma_dev_in;
  logic        dma_rqst, dma_rd_wr, dma_dev_ack, dma_ack, dma_end_flag, busy, timeout_err;

  int checks = 0;
  int errors = 0;

  dma_channel_arbiter #(.N_DEV(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n), .dev_rqst(dev_rqst), .dev_rd_wr(dev_rd_wr),
    .dev_start_addr(dev_start_addr), .dev_num_words(dev_num_words), .dev_ack_in(dev_ack_in),
    .dev_wdata(dev_wdata), .dev_dma_ack(dev_dma_ack), .dev_end_flag(dev_end_flag),
    .dev_rdata(dev_rdata), .dma_rqst(dma_rqst), .dma_rd_wr(dma_rd_wr),
    .dma_start_address(dma_start_address), .dma_num_words(dma_num_words),
    .dma_dev_ack(dma_dev_ack), .dma_dev_out(dma_dev_out), .dma_ack(dma_ack),
    .dma_end_flag(dma_end_flag), .dma_dev_in(dma_dev_in), .grant(grant), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dev_rqst = '0; dev_rd_wr = '0; dev_ack_in = '0;
    dev_start_addr = '0; dev_num_words = '0; dev_wdata = '0;
    dma_ack = 1'b0; dma_end_flag = 1'b0; dma_dev_in = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    #1;
    checks++; if (grant !== 4'b0)   begin errors++; $display("FAIL reset_grant got %b want 0000", grant); end
    checks++; if (dma_rqst !== 1'b0) begin errors++; $display("FAIL reset_rqst got %b want 0", dma_rqst); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if ({dma_start_address, dma_num_words, dma_rd_wr, timeout_err} !== 34'h0)
      begin errors++; $display("FAIL reset_latched got %h/%h/%b/%b want 0", dma_start_address, dma_num_words, dma_rd_wr, timeout_err); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    dma_ack = 1'b1;
    #1;
    checks++; if (dev_dma_ack !== 4'b0) begin errors++; $display("FAIL idle_ack_routed got %b want 0000", dev_dma_ack); end
    dma_ack = 1'b0;
    dev_rqst = 4'b0010; dev_rd_wr = 4'b0010;
    dev_start_addr[31:16] = 16'h0200; dev_num_words[31:16] = 16'd4;
    dev_wdata = 64'h1111_2222_BEEF_4444; dev_ack_in = 4'b0010; dma_dev_in = 16'hA5C3;
    tick();
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL single_grant got %b want 0010", grant); end
    checks++; if (dma_rqst !== 1'b1) begin errors++; $display("FAIL single_rqst got %b want 1", dma_rqst); end
    checks++; if (dma_start_address !== 16'h0200 || dma_num_words !== 16'd4 || dma_rd_wr !== 1'b1)
      begin errors++; $display("FAIL single_latch got %h/%h/%b want 0200/0004/1", dma_start_address, dma_num_words, dma_rd_wr); end
    checks++; if (dma_dev_out !== 16'hBEEF || dma_dev_ack !== 1'b1)
      begin errors++; $display("FAIL single_mux got %h/%b want beef/1", dma_dev_out, dma_dev_ack); end
    checks++; if (dev_rdata !== 16'hA5C3) begin errors++; $display("FAIL rdata_bcast got %h want a5c3", dev_rdata); end
    dev_ack_in = 4'b1101;
    #1;
    checks++; if (dma_dev_ack !== 1'b0) begin errors++; $display("FAIL single_mux_ack got %b want 0", dma_dev_ack); end
    for (int i = 0; i < 4; i++) begin
      dma_ack = 1'b1;
      #1;
      checks++; if (dev_dma_ack !== 4'b0010) begin errors++; $display("FAIL single_ack%0d got %b want 0010", i, dev_dma_ack); end
      tick();
    end
    dma_ack = 1'b0; dma_end_flag = 1'b1;
    #1;
    checks++; if (dev_end_flag !== 4'b0010) begin errors++; $display("FAIL single_end got %b want 0010", dev_end_flag); end
    tick();
    checks++; if (dma_rqst !== 1'b0 || grant !== 4'b0010 || busy !== 1'b1)
      begin errors++; $display("FAIL single_release got %b/%b/%b want 0/0010/1", dma_rqst, grant, busy); end
    dma_end_flag = 1'b0; dev_rqst = 4'b0000;
    tick();
    checks++; if (grant !== 4'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b/%b want 0000/0", grant, busy); end
    dev_rqst = 4'b0101;
    tick();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_rr2 got %b want 0100", grant); end
  endtask

  task automatic test_contention();
    do_reset();
    dev_rqst = 4'b0101;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL cont_first got %b want 0001", grant); end
    dma_end_flag = 1'b1;
    tick();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL cont_release got %b want 0001", grant); end
    dma_end_flag = 1'b0; dev_rqst = 4'b0100;
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL cont_gap got %b/%b want 0000/0", grant, busy); end
    tick();
    checks++; if (grant !== 4'b0100 || dma_rqst !== 1'b1) begin errors++; $display("FAIL cont_second got %b/%b want 0100/1", grant, dma_rqst); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g [5];
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    dev_rqst = 4'b1111;
    tick();
    for (int t = 0; t < 5; t++) begin
      checks++; if (grant !== exp_g[t]) begin errors++; $display("FAIL fair_%0d got %b want %b", t, grant, exp_g[t]); end
      dma_end_flag = 1'b1;
      tick();
      dma_end_flag = 1'b0; dev_rqst = 4'b1111 & ~exp_g[t];
      tick();
      dev_rqst = 4'b1111;
      tick();
    end
  endtask

  task automatic test_latch_abort();
    do_reset();
    dev_rqst = 4'b1000; dev_start_addr[63:48] = 16'h0300; dev_num_words[63:48] = 16'd8;
    tick();
    checks++; if (grant !== 4'b1000 || dma_start_address !== 16'h0300)
      begin errors++; $display("FAIL latch_grant got %b/%h want 1000/0300", grant, dma_start_address); end
    dev_start_addr[63:48] = 16'h0400; dev_num_words[63:48] = 16'd9; dev_rd_wr = 4'b1000;
    tick(); tick();
    checks++; if (dma_start_address !== 16'h0300 || dma_num_words !== 16'd8 || dma_rd_wr !== 1'b0)
      begin errors++; $display("FAIL latch_hold got %h/%h/%b want 0300/0008/0", dma_start_address, dma_num_words, dma_rd_wr); end
    dev_rqst = 4'b0000;
    tick();
    checks++; if (dma_rqst !== 1'b0 || grant !== 4'b1000 || busy !== 1'b1)
      begin errors++; $display("FAIL abort_release got %b/%b/%b want 0/1000/1", dma_rqst, grant, busy); end
    tick();
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %b/%b want 0000/0", grant, busy); end
  endtask

  task automatic test_timeout();
    do_reset();
    dev_rqst = 4'b0010;
    tick();
    repeat (15) tick();
    checks++; if (dma_rqst !== 1'b1 || timeout_err !== 1'b0)
      begin errors++; $display("FAIL tmo_early got %b/%b want 1/0", dma_rqst, timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1 || dma_rqst !== 1'b0 || grant !== 4'b0010)
      begin errors++; $display("FAIL tmo_hit got %b/%b/%b want 1/0/0010", timeout_err, dma_rqst, grant); end
    tick();
    checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_pulse got %b/%b want 0/1", timeout_err, busy); end
    dev_rqst = 4'b0000;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_idle got %b want 0", busy); end
    dev_rqst = 4'b0010;
    tick();
    repeat (10) tick();
    dma_ack = 1'b1;
    tick();
    dma_ack = 1'b0;
    repeat (15) tick();
    checks++; if (dma_rqst !== 1'b1 || timeout_err !== 1'b0)
      begin errors++; $display("FAIL tmo_ackclr got %b/%b want 1/0", dma_rqst, timeout_err); end
    tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_ackclr_hit got %b want 1", timeout_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dev_rqst = 4'b0100;
    tick();
    checks++; if (dma_rqst !== 1'b1) begin errors++; $display("FAIL rstmid_pre got %b want 1", dma_rqst); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0 || dma_rqst !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL rstmid_async got %b/%b/%b want 0000/0/0", grant, dma_rqst, busy); end
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_latch_abort();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
